k2_program_system: RTL and testbench
====================================

Name: k2_program_system

Overview:
Parametrised successor to the fixed Fibonacci program top. It wraps one K2_processor instance with a writable program RAM, so any program can be loaded at run time. A run-control FSM sets when the core executes and stops it on a cycle limit or on command. A change-triggered trace FIFO records the core's Ro output for a testbench or host to drain. It is the standard top for K2 program runs in simulation and on FPGA.

Parameters:
BITS, 8, core data width; width of Ro and of trace entries
ADDR_W, 4, program RAM address width; depth = 2**ADDR_W; must be >= 4; core's 4-bit ProgramAddress is zero-extended
TRACE_DEPTH, 16, trace FIFO entries; power of two, >= 2
CYCLE_W, 16, width of cycle counter and limit

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
prog_we  in  1  program RAM write strobe; honoured only in IDLE/DONE
prog_addr  in  ADDR_W  program RAM write address
prog_data  in  8  instruction byte to write
start  in  1  one-cycle pulse: begin a run
stop  in  1  one-cycle pulse: end the run
max_cycles  in  CYCLE_W  run length limit; 0 = unlimited; sampled on start
busy  out  1  high in RUN
done  out  1  high in DONE
Ro  out  BITS  last captured core Ro, registered
cycle_count  out  CYCLE_W  core cycles executed in current/last run
trace_data  out  BITS  FIFO head (first-word fall-through)
trace_valid  out  1  FIFO non-empty
trace_ready  in  1  consumer pops head when trace_valid & trace_ready
trace_overflow  out  1  sticky: a capture was dropped because the FIFO was full

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, Ro=0, cycle_count=0, FIFO empty, trace_overflow=0. Program RAM is not reset; its contents survive rst.
- Program RAM write:
  - Synchronous write when prog_we=1 in IDLE or DONE.
  - Ignored in RUN.
  - Asynchronous read at the zero-extended core address feeds instruction_data.
- Core reset:
  - Core rst_n is driven from a register equal to (state==RUN).
  - Core is held in reset in IDLE and DONE and released on the first RUN cycle.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start. Clears cycle_count, FIFO pointers and trace_overflow. Latches max_cycles.
  - RUN -> DONE on stop, or when cycle_count+1 == max_cycles (max_cycles != 0). The RUN lasts exactly max_cycles cycles.
  - DONE -> RUN on start, with the same clears.
  - start and stop together in RUN: stop wins. start in RUN is ignored. stop in IDLE/DONE is ignored.
  - prog_we together with start: the write happens and the run starts; the new byte is visible from the first RUN cycle.
- cycle_count:
  - Increments once per RUN cycle and saturates at all-ones.
  - Holds its value in DONE.
- Capture:
  - In RUN, core Ro is compared with a last_ro register.
  - The first RUN cycle always captures. After that, capture when core Ro != last_ro.
  - On capture: last_ro <= core Ro, Ro <= core Ro, push to FIFO.
  - Ro holds its value in DONE and IDLE (it does not follow the core's reset value).
- FIFO:
  - trace_valid rises 1 cycle after a push into an empty FIFO.
  - Push while full drops the entry and sets trace_overflow, unless a pop occurs the same cycle; then the push is accepted.
  - Push and pop together on a non-full FIFO leaves the occupancy unchanged.
  - Popping continues in DONE/IDLE.
  - Pointers wrap modulo TRACE_DEPTH, with an extra MSB for full/empty.
- rst mid-run: immediate return to IDLE, FIFO emptied, program retained.

Test Plan:
- Assert rst for 3 cycles with random inputs -> busy=0, done=0, Ro=0, trace_valid=0, cycle_count=0, trace_overflow=0.
- Load the 16-byte Fibonacci program at addresses 0..15, start with max_cycles=0, trace_ready=1 -> trace pops 0,1,2,3,5,8,13,21,34,55,89,144,233 in order (repeated 1 not recaptured), no overflow.
- Same program, max_cycles=5 -> busy high exactly 5 cycles, then done=1, cycle_count=5; writing prog_we in RUN leaves the RAM unchanged (readback via rerun identical).
- trace_ready=0, TRACE_DEPTH=16, run until 17 distinct values -> trace_overflow=1. The first 16 captures drain in order; the 17th is absent. Pop and push on the same full cycle -> no overflow.
- Pulse stop mid-run -> done=1 next cycle, Ro holds its last value. A following start clears the FIFO, trace_overflow and cycle_count, and the trace restarts at 0.
- Assert rst mid-run, release, then start without reloading -> a trace identical to the Fibonacci run, showing the program RAM was retained.

Source files
------------

// File: rtl/k2_program_system.sv
// K2 core wrapped with a writable program RAM, a run-control FSM and a change-triggered Ro trace FIFO.
// Trace entries appear one cycle after capture; a full FIFO drops captures and raises sticky overflow.

// Tiny K2-style core: LDI/ADD/OUT/JMP/JC over Ra, Rb, Ro with a 4-bit program counter.
// One instruction per cycle; no backpressure, held in async reset while rst_n is low.
module K2_processor #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      instruction_data,
  output logic [3:0]      ProgramAddress,
  output logic [BITS-1:0] Ro
);
  logic [BITS-1:0] ra, rb;
  logic            carry;
  logic [BITS:0]   sum;

  assign sum = {1'b0, ra} + {1'b0, rb};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ProgramAddress <= '0;
      ra             <= '0;
      rb             <= '0;
      Ro             <= '0;
      carry          <= 1'b0;
    end else begin
      ProgramAddress <= ProgramAddress + 4'd1;
      case (instruction_data[7:6])
        2'b00: Ro <= instruction_data[4] ? rb : ra;
        2'b01: begin
          if (instruction_data[5]) rb <= sum[BITS-1:0];
          else                     ra <= sum[BITS-1:0];
          carry <= sum[BITS];
        end
        2'b10: begin
          if (instruction_data[4]) rb <= BITS'(instruction_data[3:0]);
          else                     ra <= BITS'(instruction_data[3:0]);
        end
        default: begin
          // bit 4 selects the carry-conditional form
          if (!instruction_data[4] || carry) ProgramAddress <= instruction_data[3:0];
        end
      endcase
    end
  end
endmodule

// Generic first-word-fall-through FIFO with synchronous clear.
// Data visible one cycle after write; wr_rdy stays high when full if a read happens the same cycle.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  input  logic             rd_rdy
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, empty, do_wr, do_rd;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_vld = !empty;
  assign rd_dat = mem[rd_ptr[AW-1:0]];
  assign do_rd  = rd_rdy && !empty;
  assign wr_rdy = !full || do_rd;
  assign do_wr  = wr_vld && wr_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end
endmodule

// Run-control top: IDLE/RUN/DONE, core released only in RUN, Ro changes pushed to the trace FIFO.
// Trace latency one cycle; trace_ready backpressure fills the FIFO, then captures drop with overflow set.
module k2_program_system #(
  parameter int BITS        = 8,
  parameter int ADDR_W      = 4,
  parameter int TRACE_DEPTH = 16,
  parameter int CYCLE_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [7:0]         prog_data,
  input  logic               start,
  input  logic               stop,
  input  logic [CYCLE_W-1:0] max_cycles,
  output logic               busy,
  output logic               done,
  output logic [BITS-1:0]    Ro,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [BITS-1:0]    trace_data,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic               trace_overflow
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_n;
  logic [7:0]          prog_mem [2**ADDR_W];
  logic                core_rst_n;
  logic [3:0]          core_addr;
  logic [BITS-1:0]     core_ro, last_ro;
  logic                first_q, launch, capture, trace_wr_rdy;
  logic [CYCLE_W-1:0]  max_q;

  always_ff @(posedge clk) begin
    if (prog_we && state != RUN) prog_mem[prog_addr] <= prog_data;
  end

  K2_processor #(.BITS(BITS)) u_core (
    .clk              (clk),
    .rst_n            (core_rst_n),
    .instruction_data (prog_mem[ADDR_W'(core_addr)]),
    .ProgramAddress   (core_addr),
    .Ro               (core_ro)
  );

  always_comb begin
    state_n = state;
    launch  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          launch  = 1'b1;
        end
      end
      RUN: begin
        if (stop || (max_q != '0 && cycle_count + CYCLE_W'(1) == max_q)) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign capture = (state == RUN) && (first_q || core_ro != last_ro);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      core_rst_n     <= 1'b0;
      cycle_count    <= '0;
      max_q          <= '0;
      first_q        <= 1'b0;
      last_ro        <= '0;
      Ro             <= '0;
      trace_overflow <= 1'b0;
    end else begin
      state      <= state_n;
      core_rst_n <= (state_n == RUN);
      if (launch) begin
        cycle_count    <= '0;
        max_q          <= max_cycles;
        first_q        <= 1'b1;
        trace_overflow <= 1'b0;
      end else if (state == RUN) begin
        if (cycle_count != '1) cycle_count <= cycle_count + CYCLE_W'(1);
        first_q <= 1'b0;
        if (capture) begin
          last_ro <= core_ro;
          Ro      <= core_ro;
        end
        if (capture && !trace_wr_rdy) trace_overflow <= 1'b1;
      end
    end
  end

  fifo #(.WIDTH(BITS), .DEPTH(TRACE_DEPTH)) u_trace (
    .clk    (clk),
    .rst    (rst),
    .clr    (launch),
    .wr_vld (capture),
    .wr_dat (core_ro),
    .wr_rdy (trace_wr_rdy),
    .rd_vld (trace_valid),
    .rd_dat (trace_data),
    .rd_rdy (trace_ready)
  );
endmodule

// File: tb/tb_k2_program_system.sv
// Bench for k2_program_system: queue model of run control and trace FIFO, driven by the Fibonacci program's capture schedule.
module tb_k2_program_system;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] max_cycles = '0;
  logic        trace_ready = 1'b0;
  logic        busy, done, trace_valid, trace_overflow;
  logic [7:0]  Ro, trace_data;
  logic [15:0] cycle_count;

  k2_program_system dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .stop(stop), .max_cycles(max_cycles), .busy(busy), .done(done), .Ro(Ro),
    .cycle_count(cycle_count), .trace_data(trace_data), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_overflow(trace_overflow)
  );

  always #5 clk = ~clk;

  logic [7:0] prog_rom [16] = '{8'h80, 8'h91, 8'h00, 8'h10, 8'h40, 8'hD0, 8'h00, 8'h60,
                                8'hD0, 8'h10, 8'hC4, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
  int fib_lit [13] = '{0, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};

  int n_checks = 0, n_pass = 0;
  int log_q [$];
  int busy_cnt = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // n-th capture of a run (1-based): value and RUN cycle it happens in; program loop repeats every 48 cycles.
  function automatic int cap_val(input int n);
    int r, a, b, t;
    r = (n - 1) % 13;
    a = 1;
    b = 1;
    if (r == 0) return 0;
    for (int i = 1; i < r; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic int cap_cycle(input int n);
    int w, r, off;
    w = (n - 1) / 13;
    r = (n - 1) % 13;
    if (r == 0)          off = (w == 0) ? 1 : 4;
    else if (r == 1)     off = 5;
    else if (r == 2)     off = 11;
    else if (r % 2 == 1) off = 15 + 7 * ((r - 3) / 2);
    else                 off = 18 + 7 * ((r - 4) / 2);
    return 48 * w + off;
  endfunction

  int m_state = M_IDLE, m_k = 0, m_n = 1, m_max = 0, m_ro = 0;
  bit m_ovf = 1'b0;
  int m_q [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = M_IDLE; m_k = 0; m_n = 1; m_ro = 0; m_ovf = 1'b0;
      m_q.delete();
    end else begin
      if (trace_ready && m_q.size() != 0) void'(m_q.pop_front());
      if (m_state == M_RUN) begin
        m_k++;
        if (m_k == cap_cycle(m_n)) begin
          m_ro = cap_val(m_n);
          m_n++;
          if (m_q.size() < 16) m_q.push_back(m_ro);
          else m_ovf = 1'b1;
        end
        if (stop || (m_max != 0 && m_k == m_max)) m_state = M_DONE;
      end else if (start) begin
        m_state = M_RUN; m_k = 0; m_n = 1; m_max = int'(max_cycles); m_ovf = 1'b0;
        m_q.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_state == M_RUN));
      chk("done", 32'(done), 32'(m_state == M_DONE));
      chk("cycle_count", 32'(cycle_count), m_k);
      chk("ro", 32'(Ro), m_ro);
      chk("trace_valid", 32'(trace_valid), 32'(m_q.size() != 0));
      chk("trace_overflow", 32'(trace_overflow), 32'(m_ovf));
      if (m_q.size() != 0) chk("trace_data", 32'(trace_data), m_q[0]);
      if (trace_valid && trace_ready) log_q.push_back(int'(trace_data));
      if (busy) busy_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int mc, input logic rdy);
    max_cycles  = 16'(mc);
    trace_ready = rdy;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic chk_log(input string nm, input int base, input int cnt, input int lit_start);
    for (int i = 0; i < cnt; i++) begin
      if (base + i < log_q.size()) chk(nm, log_q[base + i], fib_lit[(lit_start + i) % 13]);
      else chk({nm, "_missing"}, 32'hFFFF_FFFF, fib_lit[(lit_start + i) % 13]);
    end
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 200 && !done; i++) step();
    chk(nm, 32'(done), 32'd1);
  endtask

  initial begin
    int base, bbase;
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      prog_we = 1'($urandom); prog_addr = 4'($urandom); prog_data = 8'($urandom);
      start = 1'($urandom); stop = 1'($urandom); max_cycles = 16'($urandom);
      trace_ready = 1'($urandom);
      step();
    end
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ro", 32'(Ro), 0);
    chk("rst_valid", 32'(trace_valid), 0);
    chk("rst_count", 32'(cycle_count), 0);
    chk("rst_ovf", 32'(trace_overflow), 0);
    prog_we = 0; start = 0; stop = 0; max_cycles = 0; trace_ready = 0;
    rst = 1'b0;
    step();

    for (int a = 0; a < 16; a++) begin
      prog_we = 1'b1; prog_addr = 4'(a); prog_data = prog_rom[a];
      step();
    end
    prog_we = 1'b0;

    // unlimited Fibonacci run, consumer always ready
    base = log_q.size();
    start_run(0, 1'b1);
    repeat (59) step();
    stop_run();
    repeat (3) step();
    chk_log("fib_trace", base, 13, 0);
    chk("fib_no_ovf", 32'(trace_overflow), 0);

    // five-cycle run with an ignored write in RUN
    base = log_q.size();
    bbase = busy_cnt;
    start_run(5, 1'b1);
    prog_we = 1'b1; prog_addr = 4'd2; prog_data = 8'h10;
    step();
    prog_we = 1'b0;
    wait_done("lim_done");
    repeat (3) step();
    chk("lim_busy_cycles", busy_cnt - bbase, 5);
    chk("lim_count", 32'(cycle_count), 5);
    chk("lim_ro", 32'(Ro), 1);
    chk("lim_log_len", log_q.size() - base, 2);
    chk_log("lim_trace", base, 2, 0);

    base = log_q.size();
    start_run(0, 1'b1);
    repeat (50) step();
    stop_run();
    repeat (3) step();
    chk_log("ram_kept_trace", base, 13, 0);

    // overflow: 17 captures into a 16-entry FIFO with no consumer
    base = log_q.size();
    start_run(63, 1'b0);
    wait_done("ovf_done");
    chk("ovf_flag", 32'(trace_overflow), 1);
    chk("ovf_ro", 32'(Ro), 3);
    chk("ovf_count", 32'(cycle_count), 63);
    trace_ready = 1'b1;
    repeat (20) step();
    chk("ovf_log_len", log_q.size() - base, 16);
    chk_log("ovf_trace", base, 16, 0);

    // stop mid-run, then restart clears FIFO, overflow and counter
    start_run(0, 1'b0);
    chk("restart_ovf_clr", 32'(trace_overflow), 0);
    chk("restart_count_clr", 32'(cycle_count), 0);
    repeat (29) step();
    stop_run();
    chk("stop_done", 32'(done), 1);
    chk("stop_ro", 32'(Ro), 21);
    repeat (3) step();
    chk("stop_ro_hold", 32'(Ro), 21);
    chk("stop_fifo_held", 32'(trace_valid), 1);
    base = log_q.size();
    start_run(0, 1'b0);
    chk("restart_fifo_clr", 32'(trace_valid), 0);
    chk("restart_count0", 32'(cycle_count), 0);
    trace_ready = 1'b1;
    repeat (20) step();
    stop_run();
    repeat (3) step();
    chk_log("restart_trace", base, 5, 0);

    // pop and push on the same cycle while full: accepted, no overflow
    base = log_q.size();
    start_run(0, 1'b0);
    repeat (62) step();
    trace_ready = 1'b1;
    stop = 1'b1;
    step();
    trace_ready = 1'b0;
    stop = 1'b0;
    chk("full_pp_no_ovf", 32'(trace_overflow), 0);
    trace_ready = 1'b1;
    repeat (20) step();
    chk("full_pp_log_len", log_q.size() - base, 17);
    chk_log("full_pp_trace", base, 17, 0);

    // reset mid-run keeps the program RAM
    start_run(0, 1'b1);
    repeat (20) step();
    rst = 1'b1;
    step();
    step();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(trace_valid), 0);
    rst = 1'b0;
    step();
    base = log_q.size();
    start_run(0, 1'b1);
    repeat (55) step();
    stop_run();
    repeat (3) step();
    chk_log("midrst_trace", base, 13, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
